jtag_scan_master: RTL and testbench

//  Host-side JTAG initiator: converts IR-scan / DR-scan / TAP-reset commands into TCK/TMS/TDI
//  bit sequences and returns the TDO bits it captures. It drives the TAP that hosts the Nios II

---
 rtl/jtag_scan_master.sv | 238 +++++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// Host-side JTAG initiator. It turns TAP-reset, IR-scan and DR-scan commands into TCK/TMS/TDI
// sequences, and it returns the TDO bits it captures. Every walk starts and ends in Run-Test/Idle.
// Latency: (bits * 2 * TCK_DIV) + 2 clk from accept to rsp_valid; rejects answer 1 clk after accept.
// Backpressure: cmd_ready is low while a scan runs or a response is held; rsp_valid holds until rsp_ready.
//
// Ports: clk/reset (synchronous, active-high); cmd_* command handshake (type, len, TDI data);
//        rsp_* response handshake (captured TDO data, error flag); busy; tck/tms/tdi registered
//        outputs; tdo from the target.
module jtag_scan_master #(
    parameter int TCK_DIV = 4,
    parameter int DR_MAX  = 38
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_type,
    input  logic [$clog2(DR_MAX+1)-1:0]  cmd_len,
    input  logic [DR_MAX-1:0]            cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DR_MAX-1:0]            rsp_data,
    output logic                         rsp_err,
    output logic                         busy,
    output logic                         tck,
    output logic                         tms,
    output logic                         tdi,
    input  logic                         tdo
);

    localparam int LW = $clog2(DR_MAX + 1);
    localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TAIL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] T_RST = 2'd0;
    localparam logic [1:0] T_IR  = 2'd1;
    localparam logic [1:0] T_DR  = 2'd2;

    logic [2:0]        state_q, state_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     div_q, div_d;
    logic              tck_q, tck_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DR_MAX-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        type_q, type_d;
    logic [LW-1:0]     len_q, len_d;
    logic [DR_MAX-1:0] data_q, data_d;

    logic              cmd_bad;
    logic              phase_end;
    logic [3:0]        hdr_pat;
    logic [LW-1:0]     hdr_last;
    logic [1:0]        hdr_nxt;
    logic [LW-1:0]     len_last;
    logic [LW-1:0]     cnt_nxt;

    assign cmd_ready = (state_q == S_IDLE) && !rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

    assign cmd_bad = (cmd_type == 2'd3) ||
                     ((cmd_type != T_RST) && ((cmd_len == '0) || (cmd_len > LW'(DR_MAX))));

    assign phase_end = (div_q == DIV_LAST);
    assign len_last  = len_q - LW'(1);
    assign cnt_nxt   = cnt_q + LW'(1);
    assign hdr_nxt   = cnt_q[1:0] + 2'd1;

    // Header TMS, bit n = TMS of header TCK n. A TAP reset is four 1s here; the shared
    // 1,0 tail then supplies the fifth 1 and the final 0 that parks the TAP in RTI.
    always_comb begin
        hdr_pat  = 4'b1111;
        hdr_last = LW'(3);
        if (type_q == T_IR) begin
            hdr_pat = 4'b0011;
        end else if (type_q == T_DR) begin
            hdr_pat  = 4'b0001;
            hdr_last = LW'(2);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        type_d      = type_q;
        len_d       = len_q;
        data_d      = data_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    rsp_data_d = '0;
                    if (cmd_bad) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        // Every walk opens with TMS=1, so the first low phase starts right away.
                        state_d = S_HDR;
                        cnt_d   = '0;
                        div_d   = '0;
                        tck_d   = 1'b0;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                        busy_d  = 1'b1;
                        type_d  = cmd_type;
                        len_d   = cmd_len;
                        data_d  = cmd_data;
                    end
                end
            end

            S_HDR, S_SHIFT, S_TAIL: begin
                div_d = phase_end ? '0 : div_q + DW'(1);
                if (phase_end && !tck_q) begin
                    // Rising TCK: TDO is taken on the same clk edge, and only for shift bits.
                    tck_d = 1'b1;
                    if (state_q == S_SHIFT) begin
                        rsp_data_d[cnt_q] = tdo;
                    end
                end else if (phase_end && tck_q) begin
                    // Falling TCK: present TMS/TDI for the next bit.
                    tck_d = 1'b0;
                    tdi_d = 1'b0;
                    case (state_q)
                        S_HDR: begin
                            if (cnt_q == hdr_last) begin
                                cnt_d = '0;
                                if (type_q == T_RST) begin
                                    state_d = S_TAIL;
                                    tms_d   = 1'b1;
                                end else begin
                                    state_d = S_SHIFT;
                                    tms_d   = (len_q == LW'(1));
                                    tdi_d   = data_q[0];
                                end
                            end else begin
                                cnt_d = cnt_nxt;
                                tms_d = hdr_pat[hdr_nxt];
                            end
                        end
                        S_SHIFT: begin
                            if (cnt_q == len_last) begin
                                state_d = S_TAIL;
                                cnt_d   = '0;
                                tms_d   = 1'b1;
                            end else begin
                                cnt_d = cnt_nxt;
                                tms_d = (cnt_nxt == len_last);
                                tdi_d = data_q[cnt_nxt];
                            end
                        end
                        default: begin
                            if (cnt_q == '0) begin
                                cnt_d = LW'(1);
                                tms_d = 1'b0;
                            end else begin
                                state_d = S_DONE;
                                tms_d   = 1'b0;
                            end
                        end
                    endcase
                end
            end

            S_DONE: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            type_q      <= T_RST;
            len_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            type_q      <= type_d;
            len_q       <= len_d;
            data_q      <= data_d;
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a TAP-controller model plays the target, and a per-cycle checker
// compares the DUT against expected TCK bit tables. Literal expectations pin the model.
// Latency / backpressure are exercised through held rsp_ready, rejects and a mid-scan reset.
module tb_jtag_scan_master;

    localparam int D  = 2;
    localparam int DM = 38;

    localparam int P_IDLE = 0, P_RUN = 1, P_RESP = 2, P_REL = 3;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6,
                   EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12,
                   PAIR = 13, EX2IR = 14, UPIR = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [37:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [37:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        tck, tms, tdi;
    logic        tdo = 1'b0;

    always #5 clk = ~clk;

    jtag_scan_master #(.TCK_DIV(D), .DR_MAX(DM)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    // Expected walk, written by the driver before each command.
    logic [63:0] exp_tms, exp_tdi;
    int          exp_n, exp_hdr, exp_len;
    logic        exp_err;
    // Literal pins for the model, also written by the driver.
    logic        lit_valid;
    int          lit_n;
    logic [63:0] lit_tms, lit_tdi;
    logic [37:0] lit_rsp;

    // Checker / target state.
    int          n_chk = 0, n_fail = 0;
    int          phase = P_IDLE;
    int          k = 0;
    logic        rst_seen = 1'b0;
    logic [37:0] exp_rsp = '0;
    int          obs_n = 0;
    logic [63:0] obs_tms = '0, obs_tdi = '0;
    int          tap_st = TLR;
    logic [9:0]  ir_sr = '0;
    logic        dr_sr = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    // Target TAP: IR captures 0x001, DR is a 1-bit register capturing 1.
    task automatic tap_rise(input logic m, input logic d);
        case (tap_st)
            CAPIR:   ir_sr = 10'h001;
            CAPDR:   dr_sr = 1'b1;
            SHIR:    ir_sr = {d, ir_sr[9:1]};
            SHDR:    dr_sr = d;
            default: ;
        endcase
        tap_st = tap_next(tap_st, m);
    endtask

    task automatic tap_fall();
        if (tap_st == SHIR)      tdo = ir_sr[0];
        else if (tap_st == SHDR) tdo = dr_sr;
        else                     tdo = 1'b0;
    endtask

    always @(negedge clk) begin
        int bi, ph;
        if (rst_seen) begin
            chk("rst_tck", tck, 0);
            chk("rst_tms", tms, 1);
            chk("rst_tdi", tdi, 0);
            chk("rst_cmd_ready", cmd_ready, 1);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_busy", busy, 0);
        end
        rst_seen = reset;
        if (reset) begin
            phase = P_IDLE;
        end else begin
            case (phase)
                P_RUN: begin
                    bi = k / (2 * D);
                    ph = k % (2 * D);
                    if (k < 2 * D * exp_n) begin
                        chk("run_tck", tck, (ph >= D));
                        chk("run_tms", tms, exp_tms[bi]);
                        chk("run_tdi", tdi, exp_tdi[bi]);
                        chk("run_busy", busy, 1);
                        chk("run_rsp_valid", rsp_valid, 0);
                        chk("run_cmd_ready", cmd_ready, 0);
                        if (ph == 0 && k > 0) tap_fall();
                        if (ph == D) begin
                            obs_tms[obs_n] = tms;
                            obs_tdi[obs_n] = tdi;
                            obs_n++;
                            if (bi >= exp_hdr && bi < exp_hdr + exp_len)
                                exp_rsp[bi - exp_hdr] = tdo;
                            tap_rise(tms, tdi);
                        end
                    end else begin
                        chk("done_tck", tck, 0);
                        chk("done_tms", tms, 0);
                        chk("done_tdi", tdi, 0);
                        chk("done_busy", busy, 1);
                        chk("done_rsp_valid", rsp_valid, 0);
                        tap_fall();
                        phase = P_RESP;
                    end
                    k++;
                end
                P_RESP: begin
                    chk("rsp_valid", rsp_valid, 1);
                    chk("rsp_err", rsp_err, exp_err);
                    chk("rsp_data", rsp_data, exp_rsp);
                    chk("rsp_busy", busy, 0);
                    chk("rsp_tck", tck, 0);
                    chk("rsp_cmd_ready", cmd_ready, 0);
                    if (rsp_ready) phase = P_REL;
                end
                P_REL: begin
                    chk("rel_rsp_valid", rsp_valid, 0);
                    chk("rel_cmd_ready", cmd_ready, 1);
                    if (lit_valid) begin
                        chk("lit_tck_count", obs_n, lit_n);
                        chk("lit_tms_bits", obs_tms, lit_tms);
                        chk("lit_tdi_bits", obs_tdi, lit_tdi);
                        chk("lit_rsp", exp_rsp, lit_rsp);
                    end
                    if (!exp_err) chk("tap_in_rti", tap_st, RTI);
                    phase = P_IDLE;
                end
                default: begin
                    chk("idle_tck", tck, 0);
                    chk("idle_busy", busy, 0);
                end
            endcase
            if (cmd_valid && cmd_ready && phase == P_IDLE) begin
                obs_n   = 0;
                obs_tms = '0;
                obs_tdi = '0;
                exp_rsp = '0;
                k       = 0;
                phase   = exp_err ? P_RESP : P_RUN;
            end
        end
    end

    // TMS/TDI per TCK bit, straight from the command rules.
    task automatic build_exp(input logic [1:0] t, input logic [5:0] len, input logic [37:0] data);
        int n;
        n = 0;
        exp_tms = '0;
        exp_tdi = '0;
        exp_len = 0;
        exp_err = (t == 2'd3) || (t != 2'd0 && (len == 6'd0 || len > 6'd38));
        if (t == 2'd0) begin
            for (int i = 0; i < 5; i++) begin exp_tms[n] = 1'b1; n++; end
            n++;
            exp_hdr = n;
        end else begin
            exp_tms[n] = 1'b1; n++;
            if (t == 2'd1) begin exp_tms[n] = 1'b1; n++; end
            n += 2;
            exp_hdr = n;
            exp_len = int'(len);
            for (int i = 0; i < int'(len) && i < 38; i++) begin
                exp_tms[n] = (i == int'(len) - 1);
                exp_tdi[n] = data[i];
                n++;
            end
            exp_tms[n] = 1'b1; n++;
            n++;
        end
        exp_n = exp_err ? 0 : n;
    endtask

    task automatic wait_phase(input int p, input string nm);
        int w;
        w = 0;
        while (phase != p && w < 3000) begin @(posedge clk); #1; w++; end
        if (phase != p) begin
            $display("FAIL timeout %s: got phase %0d expected %0d", nm, phase, p);
            $fatal(1, "bench stopped");
        end
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [5:0] len, input logic [37:0] data,
                           input int hold, input int ln, input logic [63:0] lt,
                           input logic [63:0] ld, input logic [37:0] lr);
        build_exp(t, len, data);
        lit_valid = 1'b1;
        lit_n     = ln;
        lit_tms   = lt;
        lit_tdi   = ld;
        lit_rsp   = lr;
        @(posedge clk); #1;
        cmd_type  = t;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (hold > 0) begin
            wait_phase(P_RESP, "rsp_wait");
            repeat (hold) @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        wait_phase(P_IDLE, "cmd_done");
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // TAP reset (length field ignored even when 0)
        run_cmd(2'd0, 6'd0, 38'h0, 0, 6, 64'h1F, 64'h0, 38'h0);
        // IR scan, capture 0x001
        run_cmd(2'd1, 6'd10, 38'h00E, 0, 16, 64'h6003, 64'h00E0, 38'h001);
        // Full-length DR scan through the 1-bit DR
        run_cmd(2'd2, 6'd38, 38'h2A_5555_AAAA, 0, 43, 64'h0000_0300_0000_0001,
                64'h152_AAAD_5550, 38'h14_AAAB_5555);
        // Rejects: no TCK activity, error response
        run_cmd(2'd2, 6'd0,  38'h3, 0, 0, 64'h0, 64'h0, 38'h0);
        run_cmd(2'd2, 6'd39, 38'h3, 0, 0, 64'h0, 64'h0, 38'h0);
        run_cmd(2'd3, 6'd5,  38'h3, 0, 0, 64'h0, 64'h0, 38'h0);
        run_cmd(2'd1, 6'd39, 38'h3, 0, 0, 64'h0, 64'h0, 38'h0);
        // Single-bit DR scan with the response held for 20 clk
        run_cmd(2'd2, 6'd1, 38'h1, 20, 6, 64'h19, 64'h08, 38'h1);
        // Short DR scan
        run_cmd(2'd2, 6'd5, 38'h16, 0, 10, 64'h181, 64'hB0, 38'h0D);

        // Reset during shift bit 17 of a 38-bit DR scan
        build_exp(2'd2, 6'd38, 38'h2A_5555_AAAA);
        lit_valid = 1'b0;
        @(posedge clk); #1;
        cmd_type  = 2'd2;
        cmd_len   = 6'd38;
        cmd_data  = 38'h2A_5555_AAAA;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        w = 0;
        while (!(phase == P_RUN && k >= (3 + 17) * 2 * D + 1) && w < 3000) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 3000) begin
            $display("FAIL timeout abort_wait: got k %0d expected %0d", k, (3 + 17) * 2 * D + 1);
            $fatal(1, "bench stopped");
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // TAP state is unknown after the abort; a TAP reset must bring it back to RTI
        run_cmd(2'd0, 6'd7, 38'h0, 0, 6, 64'h1F, 64'h0, 38'h0);
        run_cmd(2'd1, 6'd10, 38'h3FF, 0, 16, 64'h6003, 64'h3FF0, 38'h001);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
